// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial bit-pattern detector.
// A host loads a 1..MAX_LEN bit pattern through a valid/ready config port.
// The serial input is compared against that pattern, and dout is a Mealy
// pulse raised in the same cycle as the completing bit. match_cnt is a
// saturating count of matches.
// Optional feature macro: SEQ_OVERLAP_EN.
//   Defined:   cfg_overlap is latched and selects overlapping matches.
//   Undefined: matching is always non-overlapping.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               dout,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-2:0] hist;       // previous len-1 bits, newest at bit 0
    logic [LEN_W-1:0]   fill;       // valid bits in the window, capped at len_q
    logic               cfg_fire;   // handshake this cycle
    logic               cfg_ok;     // offered length is legal
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] window;
    logic [LEN_W:0]     fill_p1;
    logic               full;
    logic               hit;

    assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign window  = {hist, din};
    assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    // Including the bit arriving now, the window holds at least len bits.
    assign full    = fill_p1 >= {1'b0, len_q};
    assign hit     = ((window ^ pattern_q) & mask) == '0;

    // Select the low len_q bits of the window for comparison.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= UNCFG;
        else        state <= state_nxt;
    end

    // Next-state and Mealy outputs. LOAD is the only state that refuses config.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        cfg_fire  = 1'b0;
        armed     = 1'b0;
        dout      = 1'b0;
        case (state)
            UNCFG: begin
                cfg_ready = 1'b1;
                cfg_fire  = cfg_valid;
                if (cfg_valid && cfg_ok) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                cfg_ready = 1'b1;
                cfg_fire  = cfg_valid;
                armed     = 1'b1;
                dout      = din_valid && full && hit;
                if (cfg_valid && cfg_ok) state_nxt = LOAD;
            end
            default: state_nxt = UNCFG;
        endcase
    end

    // Latch an accepted config. A rejected word leaves the stored config intact.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
        end else if (cfg_fire && cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
`ifdef SEQ_OVERLAP_EN
            overlap_q <= cfg_overlap;
`else
            overlap_q <= 1'b0;
`endif
        end
    end

`ifndef SEQ_OVERLAP_EN
    // The port stays present even though non-overlap mode is forced.
    logic unused_overlap;
    assign unused_overlap = cfg_overlap;
`endif

    // Registered reject pulse for an illegal length.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cfg_err <= 1'b0;
        else        cfg_err <= cfg_fire && !cfg_ok;
    end

    // Bit history and fill. In non-overlap mode, fill restarts after a match
    // so that no bit of the matched window is reused.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (state == LOAD) begin
            hist <= '0;
            fill <= '0;
        end else if (state == RUN && din_valid) begin
            hist <= window[MAX_LEN-2:0];
            if (dout && !overlap_q)  fill <= '0;
            else if (fill != len_q)  fill <= fill + LEN_W'(1);
        end
    end

    // Saturating match counter. An accepted config clears it, and that clear
    // wins over both cnt_clr and a same-cycle match.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if ((cfg_fire && cfg_ok) || cnt_clr) begin
            match_cnt <= '0;
        end else if (dout && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl. Two instances share the same stimulus:
//   u_dut uses CNT_W = 8.
//   u_sat uses CNT_W = 2, which exercises counter saturation.
// The reference model keeps the received bits as a queue and compares the
// newest len bits against the stored pattern.
module tb_seq_detect_ctrl;

    localparam int MAXL = 8;
    localparam int LW   = 4;
`ifdef SEQ_OVERLAP_EN
    localparam bit OVL_EN = 1'b1;
`else
    localparam bit OVL_EN = 1'b0;
`endif
    localparam int S_UN  = 0;
    localparam int S_LD  = 1;
    localparam int S_RUN = 2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [MAXL-1:0] cfg_pattern = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic            cfg_overlap = 1'b0;
    logic            din_valid = 1'b0;
    logic            din = 1'b0;
    logic            cnt_clr = 1'b0;
    logic            cfg_ready, cfg_err, dout, armed;
    logic [7:0]      match_cnt;
    logic            cfg_ready2, cfg_err2, dout2, armed2;
    logic [1:0]      match_cnt2;

    seq_detect_ctrl #(.MAX_LEN(MAXL), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_err(cfg_err), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
        .dout(dout), .armed(armed), .match_cnt(match_cnt));

    seq_detect_ctrl #(.MAX_LEN(MAXL), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_err(cfg_err2), .din_valid(din_valid), .din(din), .cnt_clr(cnt_clr),
        .dout(dout2), .armed(armed2), .match_cnt(match_cnt2));

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int        m_state;
    logic [MAXL-1:0] m_pat;
    int        m_len;
    bit        m_ovl;
    bit        q[$];
    int        m_cnt;
    bit        m_err;

    typedef struct {
        bit dv;
        bit d;
        bit exp_dout;
        int exp_cnt;
    } vec_t;
    vec_t tbl[15];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_state = S_UN; m_pat = '0; m_len = 0; m_ovl = 0;
        q.delete(); m_cnt = 0; m_err = 0;
    endtask

    // Does the current input complete the stored pattern?
    function automatic bit m_match();
        bit b;
        if (m_state != S_RUN || !din_valid) return 1'b0;
        if (q.size() < m_len - 1) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            b = (k == m_len - 1) ? din : q[q.size() - (m_len - 1) + k];
            if (b != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic compare_model();
        bit mt;
        mt = m_match();
        check("dout",      dout,       mt);
        check("dout2",     dout2,      mt);
        check("cfg_ready", cfg_ready,  m_state != S_LD);
        check("armed",     armed,      m_state == S_RUN);
        check("cfg_err",   cfg_err,    m_err);
        check("match_cnt", match_cnt,  sat(m_cnt, 255));
        check("match_cnt2", match_cnt2, sat(m_cnt, 3));
    endtask

    // One rising edge; the model advances using the inputs held across it.
    task automatic clk_edge();
        bit mt, hs, ok, dv, d, clr, ov;
        logic [MAXL-1:0] pat;
        int len;
        mt  = m_match();
        hs  = cfg_valid && (m_state != S_LD);
        len = int'(cfg_len);
        ok  = (len >= 1) && (len <= MAXL);
        dv = din_valid; d = din; clr = cnt_clr; ov = cfg_overlap; pat = cfg_pattern;
        @(posedge clock);
        if (clr) m_cnt = 0;
        else if (mt) m_cnt++;
        m_err = hs && !ok;
        if (hs && ok) begin
            m_pat = pat; m_len = len; m_ovl = OVL_EN ? ov : 1'b0;
            m_cnt = 0; m_state = S_LD;
        end else if (m_state == S_LD) begin
            m_state = S_RUN; q.delete();
        end else if (m_state == S_RUN && dv) begin
            if (mt && !m_ovl) q.delete();
            else begin
                q.push_back(d);
                if (q.size() > MAXL) void'(q.pop_front());
            end
        end
        @(negedge clock);
    endtask

    task automatic step();
        #1 compare_model();
        clk_edge();
    endtask

    task automatic do_cfg(input logic [MAXL-1:0] pat, input int len, input bit ov);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = LW'(len); cfg_overlap = ov;
        din_valid = 1'b0;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    task automatic send(input bit b);
        din_valid = 1'b1; din = b;
        step();
        din_valid = 1'b0;
    endtask

    initial begin
        bit stream[15];
        int sat_exp[5];
        stream  = '{1,0,1,1,0,1,0,1,1,0,1,1,0,1,0};
        sat_exp = '{1,2,3,3,3};
        for (int i = 0; i < 15; i++) begin
            tbl[i].dv       = 1'b1;
            tbl[i].d        = stream[i];
            tbl[i].exp_dout = (i == 5 || i == 10);
            tbl[i].exp_cnt  = (i <= 5) ? 0 : ((i <= 10) ? 1 : 2);
        end
        model_reset();

        // In reset, with din toggling, every output holds its reset value.
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1; din = i[0];
            @(posedge clock); #1;
            check("rst_dout", dout, 0);
            check("rst_armed", armed, 0);
            check("rst_ready", cfg_ready, 1);
            check("rst_cnt", match_cnt, 0);
            @(negedge clock);
        end
        reset = 1'b1;
        // Unconfigured: din is ignored.
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b1; din = 1'b1;
            #1 check("uncfg_dout", dout, 0);
            clk_edge();
        end
        din_valid = 1'b0;

        // Non-overlap 1101, table driven.
        do_cfg(8'b1101, 4, 1'b0);
        for (int i = 0; i < 15; i++) begin
            din_valid = tbl[i].dv; din = tbl[i].d;
            #1 compare_model();
            check("tbl_dout", dout, tbl[i].exp_dout);
            check("tbl_cnt", match_cnt, tbl[i].exp_cnt);
            clk_edge();
        end
        din_valid = 1'b0;
        check("tbl_final_cnt", match_cnt, 2);

        // Same stream with overlap requested.
        do_cfg(8'b1101, 4, 1'b1);
        for (int i = 0; i < 15; i++) send(stream[i]);
        check("ovl_final_cnt", match_cnt, OVL_EN ? 3 : 2);

        // Illegal lengths are rejected; state and pattern are kept.
        cfg_valid = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'hFF;
        step();
        cfg_valid = 1'b0;
        check("err_len0", cfg_err, 1);
        check("err_len0_armed", armed, 1);
        step();
        check("err_clear", cfg_err, 0);
        cfg_valid = 1'b1; cfg_len = 4'd9; cfg_pattern = 8'h00;
        step();
        cfg_valid = 1'b0;
        check("err_len9", cfg_err, 1);
        check("err_len9_armed", armed, 1);
        send(1); send(1); send(0);
        din_valid = 1'b1; din = 1'b1;
        #1 check("kept_pattern_match", dout, 1);
        compare_model();
        clk_edge();
        din_valid = 1'b0;

        // An asynchronous reset mid-run returns outputs at once.
        #2 reset = 1'b0;
        #1;
        check("arst_armed", armed, 0);
        check("arst_ready", cfg_ready, 1);
        check("arst_cnt", match_cnt, 0);
        check("arst_dout", dout, 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Saturation on the 2-bit counter, then cnt_clr beats a match.
        do_cfg(8'b1, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(1);
            check("sat_cnt2", match_cnt2, sat_exp[i]);
        end
        din_valid = 1'b1; din = 1'b1; cnt_clr = 1'b1;
        #1 check("clr_match_dout", dout, 1);
        step();
        cnt_clr = 1'b0; din_valid = 1'b0;
        check("clr_cnt2", match_cnt2, 0);
        check("clr_cnt", match_cnt, 0);

        // Reloading in RUN discards a partial window; LOAD lasts one cycle.
        do_cfg(8'b1101, 4, 1'b0);
        send(1); send(1); send(0);
        cfg_valid = 1'b1; cfg_pattern = 8'b1101; cfg_len = 4'd4; cfg_overlap = 1'b0;
        step();
        cfg_valid = 1'b0;
        din_valid = 1'b1; din = 1'b1;
        #1 check("load_ready", cfg_ready, 0);
        check("load_cnt", match_cnt, 0);
        compare_model();
        clk_edge();
        #1 check("post_load_ready", cfg_ready, 1);
        check("reload_no_match", dout, 0);
        compare_model();
        clk_edge();
        din_valid = 1'b0;

        // Randomised traffic against the model.
        do_cfg(8'($urandom), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3000; i++) begin
            cfg_valid   = ($urandom_range(0, 29) == 0);
            cfg_len     = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 10))
                                                      : LW'($urandom_range(1, 3));
            cfg_pattern = 8'($urandom);
            cfg_overlap = 1'($urandom_range(0, 1));
            din_valid   = ($urandom_range(0, 3) != 0);
            din         = 1'($urandom_range(0, 1));
            cnt_clr     = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
